// File: rtl/cpu_core.sv
// Minimal 6502-style core: immediate ALU/loads, transfers, inc/dec, carry control.
// Two-clock FETCH/EXEC sequencer against a combinational program memory.
module cpu_core #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  din,
  output logic [15:0] addr,
  output logic        clk_out,
  output logic [7:0]  a_out,
  output logic [7:0]  x_out,
  output logic [7:0]  y_out,
  output logic [7:0]  opcode_out,
  output logic [15:0] pc_out,
  output logic [3:0]  opcode_state_out,
  output logic [7:0]  alu_opcode_out,
  output logic [7:0]  alu_out_out,
  output logic        alu_cout_out
);

  typedef enum logic [3:0] {
    FETCH = 4'd0,
    EXEC  = 4'd1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  a;
  logic [7:0]  x;
  logic [7:0]  y;
  logic [7:0]  op;
  logic [15:0] pc;
  logic        c;
  logic        z;
  logic        n;
  logic        v;

  logic [7:0]  opnd;
  logic [8:0]  sum;
  logic        ovf;
  logic [7:0]  res;
  logic        imm;
  logic        wr_a;
  logic        wr_x;
  logic        wr_y;
  logic        wr_nz;
  logic        wr_c;
  logic        wr_v;
  logic        c_new;

  // SBC is ADC of the inverted operand; carry-in doubles as not-borrow
  assign opnd = (op == 8'hE9) ? ~din : din;
  assign sum  = {1'b0, a} + {1'b0, opnd} + {8'd0, c};
  assign ovf  = (a[7] == opnd[7]) && (sum[7] != a[7]);

  // Decode the latched opcode into a result and register/flag write enables
  always_comb begin
    res   = din;
    imm   = 1'b0;
    wr_a  = 1'b0;
    wr_x  = 1'b0;
    wr_y  = 1'b0;
    wr_nz = 1'b0;
    wr_c  = 1'b0;
    wr_v  = 1'b0;
    c_new = c;
    case (op)
      8'hA9: begin imm = 1'b1; wr_a = 1'b1; wr_nz = 1'b1; end
      8'hA2: begin imm = 1'b1; wr_x = 1'b1; wr_nz = 1'b1; end
      8'hA0: begin imm = 1'b1; wr_y = 1'b1; wr_nz = 1'b1; end
      8'h69, 8'hE9: begin
        imm   = 1'b1;
        res   = sum[7:0];
        wr_a  = 1'b1;
        wr_nz = 1'b1;
        wr_c  = 1'b1;
        wr_v  = 1'b1;
        c_new = sum[8];
      end
      8'h29: begin
        imm = 1'b1; res = a & din; wr_a = 1'b1; wr_nz = 1'b1;
      end
      8'h49: begin
        imm = 1'b1; res = a ^ din; wr_a = 1'b1; wr_nz = 1'b1;
      end
      8'h09: begin
        imm = 1'b1; res = a | din; wr_a = 1'b1; wr_nz = 1'b1;
      end
      8'h38: begin wr_c = 1'b1; c_new = 1'b1; end
      8'h18: begin wr_c = 1'b1; c_new = 1'b0; end
      8'hAA: begin res = a; wr_x = 1'b1; wr_nz = 1'b1; end
      8'hA8: begin res = a; wr_y = 1'b1; wr_nz = 1'b1; end
      8'h8A: begin res = x; wr_a = 1'b1; wr_nz = 1'b1; end
      8'h98: begin res = y; wr_a = 1'b1; wr_nz = 1'b1; end
      8'hE8: begin res = x + 8'd1; wr_x = 1'b1; wr_nz = 1'b1; end
      8'hC8: begin res = y + 8'd1; wr_y = 1'b1; wr_nz = 1'b1; end
      8'hCA: begin res = x - 8'd1; wr_x = 1'b1; wr_nz = 1'b1; end
      8'h88: begin res = y - 8'd1; wr_y = 1'b1; wr_nz = 1'b1; end
      default: begin end
    endcase
  end

  // Sequencer simply alternates between fetch and execute
  always_comb begin
    state_nxt = FETCH;
    if (state == FETCH) state_nxt = EXEC;
  end

  // Architectural state: opcode latch on FETCH, register/flag writeback on EXEC
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      a     <= 8'h00;
      x     <= 8'h00;
      y     <= 8'h00;
      op    <= 8'h00;
      pc    <= RESET_PC;
      c     <= 1'b0;
      z     <= 1'b0;
      n     <= 1'b0;
      v     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == FETCH) begin
        op <= din;
        pc <= pc + 16'd1;
      end else begin
        if (imm)   pc <= pc + 16'd1;
        if (wr_a)  a  <= res;
        if (wr_x)  x  <= res;
        if (wr_y)  y  <= res;
        if (wr_c)  c  <= c_new;
        if (wr_v)  v  <= ovf;
        if (wr_nz) begin
          z <= (res == 8'h00);
          n <= res[7];
        end
      end
    end
  end

  assign addr             = pc;
  assign clk_out          = clk;
  assign a_out            = a;
  assign x_out            = x;
  assign y_out            = y;
  assign opcode_out       = op;
  assign pc_out           = pc;
  assign opcode_state_out = state;
  assign alu_opcode_out   = op;
  assign alu_out_out      = res;
  assign alu_cout_out     = c;

endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core: directed program, expected retire state queued,
// monitor pops and compares at every instruction retirement.
module tb_cpu_core;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  din;
  logic [15:0] addr;
  logic        clk_out;
  logic [7:0]  a_out;
  logic [7:0]  x_out;
  logic [7:0]  y_out;
  logic [7:0]  opcode_out;
  logic [15:0] pc_out;
  logic [3:0]  st;
  logic [7:0]  alu_op;
  logic [7:0]  alu_out;
  logic        cout;

  logic [7:0] mem [0:255];
  assign din = mem[addr[7:0]];

  always #5 clk = ~clk;

  cpu_core #(.RESET_PC(16'h0000)) dut (
    .clk(clk),
    .reset(reset),
    .din(din),
    .addr(addr),
    .clk_out(clk_out),
    .a_out(a_out),
    .x_out(x_out),
    .y_out(y_out),
    .opcode_out(opcode_out),
    .pc_out(pc_out),
    .opcode_state_out(st),
    .alu_opcode_out(alu_op),
    .alu_out_out(alu_out),
    .alu_cout_out(cout)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        c;
    logic [15:0] pc;
    logic        ac;
    logic [7:0]  alu;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic ex(input logic [7:0] a, input logic [7:0] x,
                    input logic [7:0] y, input logic c,
                    input logic [15:0] pc, input logic ac,
                    input logic [7:0] alu);
    exp_t e;
    e.a = a; e.x = x; e.y = y; e.c = c;
    e.pc = pc; e.ac = ac; e.alu = alu;
    q.push_back(e);
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while (q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending want 0", q.size());
      q.delete();
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_a"}, {8'h0, a_out}, 16'h0000);
    chk({tag, "_x"}, {8'h0, x_out}, 16'h0000);
    chk({tag, "_y"}, {8'h0, y_out}, 16'h0000);
    chk({tag, "_pc"}, pc_out, 16'h0000);
    chk({tag, "_addr"}, addr, 16'h0000);
    chk({tag, "_op"}, {8'h0, opcode_out}, 16'h0000);
    chk({tag, "_state"}, {12'h0, st}, 16'h0000);
    chk({tag, "_c"}, {15'h0, cout}, 16'h0000);
  endtask

  // Monitor: checks state alternation, captures EXEC ALU output, compares on retire
  logic [3:0] prev = 4'd0;
  logic [7:0] alu_s = 8'h00;
  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      prev = 4'd0;
    end else begin
      chk("state_seq", {12'h0, st}, (prev == 4'd0) ? 16'd1 : 16'd0);
      if (st == 4'd1) begin
        alu_s = alu_out;
      end else if (prev == 4'd1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_retire got pc %h want none", pc_out);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("a", {8'h0, a_out}, {8'h0, e.a});
          chk("x", {8'h0, x_out}, {8'h0, e.x});
          chk("y", {8'h0, y_out}, {8'h0, e.y});
          chk("c", {15'h0, cout}, {15'h0, e.c});
          chk("pc", pc_out, e.pc);
          chk("addr", addr, e.pc);
          if (e.ac) chk("alu_out", {8'h0, alu_s}, {8'h0, e.alu});
        end
      end
      prev = st;
    end
  end

  logic [7:0] prog [39] = '{
    8'hA9, 8'h03, 8'h38, 8'hE9, 8'h02, 8'h18, 8'h69, 8'h04,
    8'h29, 8'h05, 8'h49, 8'h06, 8'h09, 8'h07,
    8'hAA, 8'hA8, 8'hA2, 8'h15, 8'h8A, 8'h98,
    8'hE8, 8'hC8, 8'hCA, 8'h88,
    8'hA9, 8'hFF, 8'h18, 8'h69, 8'h01,
    8'hA2, 8'h00, 8'hCA, 8'h02,
    8'h38, 8'h69, 8'h10, 8'h38, 8'h69, 8'h01
  };

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'hEA;
    for (int i = 0; i < 39; i++) mem[i] = prog[i];

    #2;
    chk_reset("por");

    //  a      x      y      c     pc        ac    alu
    ex(8'h03, 8'h00, 8'h00, 1'b0, 16'h0002, 1'b1, 8'h03);
    ex(8'h03, 8'h00, 8'h00, 1'b1, 16'h0003, 1'b0, 8'h00);
    ex(8'h01, 8'h00, 8'h00, 1'b1, 16'h0005, 1'b1, 8'h01);
    ex(8'h01, 8'h00, 8'h00, 1'b0, 16'h0006, 1'b0, 8'h00);
    ex(8'h05, 8'h00, 8'h00, 1'b0, 16'h0008, 1'b1, 8'h05);
    ex(8'h05, 8'h00, 8'h00, 1'b0, 16'h000A, 1'b1, 8'h05);
    ex(8'h03, 8'h00, 8'h00, 1'b0, 16'h000C, 1'b1, 8'h03);
    ex(8'h07, 8'h00, 8'h00, 1'b0, 16'h000E, 1'b1, 8'h07);
    ex(8'h07, 8'h07, 8'h00, 1'b0, 16'h000F, 1'b1, 8'h07);
    ex(8'h07, 8'h07, 8'h07, 1'b0, 16'h0010, 1'b1, 8'h07);
    ex(8'h07, 8'h15, 8'h07, 1'b0, 16'h0012, 1'b1, 8'h15);
    ex(8'h15, 8'h15, 8'h07, 1'b0, 16'h0013, 1'b1, 8'h15);
    ex(8'h07, 8'h15, 8'h07, 1'b0, 16'h0014, 1'b1, 8'h07);
    ex(8'h07, 8'h16, 8'h07, 1'b0, 16'h0015, 1'b1, 8'h16);
    ex(8'h07, 8'h16, 8'h08, 1'b0, 16'h0016, 1'b1, 8'h08);
    ex(8'h07, 8'h15, 8'h08, 1'b0, 16'h0017, 1'b1, 8'h15);
    ex(8'h07, 8'h15, 8'h07, 1'b0, 16'h0018, 1'b1, 8'h07);
    ex(8'hFF, 8'h15, 8'h07, 1'b0, 16'h001A, 1'b1, 8'hFF);
    ex(8'hFF, 8'h15, 8'h07, 1'b0, 16'h001B, 1'b0, 8'h00);
    ex(8'h00, 8'h15, 8'h07, 1'b1, 16'h001D, 1'b1, 8'h00);
    ex(8'h00, 8'h00, 8'h07, 1'b1, 16'h001F, 1'b1, 8'h00);
    ex(8'h00, 8'hFF, 8'h07, 1'b1, 16'h0020, 1'b1, 8'hFF);
    ex(8'h00, 8'hFF, 8'h07, 1'b1, 16'h0021, 1'b0, 8'h00);
    ex(8'h00, 8'hFF, 8'h07, 1'b1, 16'h0022, 1'b0, 8'h00);
    ex(8'h11, 8'hFF, 8'h07, 1'b0, 16'h0024, 1'b1, 8'h11);
    ex(8'h11, 8'hFF, 8'h07, 1'b1, 16'h0025, 1'b0, 8'h00);

    #10 reset = 1'b1;
    drain(200);

    begin
      int g = 0;
      while (st != 4'd1 && g < 10) begin
        @(negedge clk);
        g++;
      end
    end
    chk("pre_reset_op", {8'h0, opcode_out}, 16'h0069);
    chk("clk_out", {15'h0, clk_out}, {15'h0, clk});

    #1 reset = 1'b0;
    #1;
    chk_reset("mid");
    ex(8'h03, 8'h00, 8'h00, 1'b0, 16'h0002, 1'b1, 8'h03);
    #2 reset = 1'b1;
    drain(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
